// File: rtl/alu_sequencer.sv
// alu_sequencer
// Command-side initiator for the ALU subsystem. Host commands (operands +
// opcode) are queued in a small circular FIFO and issued one at a time into
// the ALU start/done handshake. Each result and its carry/zero flags are
// captured in a one-entry result register that the host drains with res_rd.
// If the ALU never signals done, a result is forced with res_timeout set.
//
// Ports:
//   clk, reset_a                   clock, synchronous active-high reset
//   cmd_wr, cmd_dataa/datab/opcode host command write
//   cmd_full, cmd_overflow         FIFO full, sticky dropped-write flag
//   alu_dataa/datab/opcode, alu_start   drive to the ALU
//   alu_out, alu_carry, alu_zero, alu_done   response from the ALU
//   res_valid, res_data, res_carry, res_zero, res_timeout   result register
//   res_rd                         host acknowledge, frees the result register
//   busy                           registered: FSM active or FIFO non-empty
module alu_sequencer #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_a,
   input  logic        cmd_wr,
   input  logic [15:0] cmd_dataa,
   input  logic [15:0] cmd_datab,
   input  logic [3:0]  cmd_opcode,
   output logic        cmd_full,
   output logic        cmd_overflow,
   output logic [15:0] alu_dataa,
   output logic [15:0] alu_datab,
   output logic [3:0]  alu_opcode,
   output logic        alu_start,
   input  logic [31:0] alu_out,
   input  logic        alu_carry,
   input  logic        alu_zero,
   input  logic        alu_done,
   output logic        res_valid,
   output logic [31:0] res_data,
   output logic        res_carry,
   output logic        res_zero,
   output logic        res_timeout,
   input  logic        res_rd,
   output logic        busy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   // The timer counts completed WAIT cycles; the TIMEOUT-th WAIT cycle is the
   // one that starts with the timer at TIMEOUT-1.
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [15:0] mem_a  [DEPTH];
   logic [15:0] mem_b  [DEPTH];
   logic [3:0]  mem_op [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [TMR_W-1:0] tmr;

   logic empty;
   logic push;
   logic pop;
   logic done_hit;
   logic tmo_hit;

   // Full is decoded from the pre-edge count, so a write in the same cycle
   // as a pop on a full FIFO is still dropped.
   assign cmd_full = (count == FULL_CNT);
   assign empty    = (count == '0);
   assign push     = cmd_wr && !cmd_full;
   assign pop      = (state == ST_IDLE) && !empty && !res_valid;
   assign done_hit = (state == ST_WAIT) && alu_done;
   assign tmo_hit  = (state == ST_WAIT) && !alu_done && (tmr == TMR_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset_a) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!empty && !res_valid) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (done_hit || tmo_hit) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      alu_start = 1'b0;
      if (state == ST_ISSUE) alu_start = 1'b1;
   end

   // FIFO storage; entries are only meaningful while counted, so no reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr]  <= cmd_dataa;
         mem_b[wr_ptr]  <= cmd_datab;
         mem_op[wr_ptr] <= cmd_opcode;
      end
   end

   // FIFO pointers, occupancy and overflow flag
   always_ff @(posedge clk) begin
      if (reset_a) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         cmd_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (cmd_wr && cmd_full) cmd_overflow <= 1'b1;
      end
   end

   // Issue registers hold the operands stable until the next issue
   always_ff @(posedge clk) begin
      if (reset_a) begin
         alu_dataa  <= '0;
         alu_datab  <= '0;
         alu_opcode <= '0;
      end else if (pop) begin
         alu_dataa  <= mem_a[rd_ptr];
         alu_datab  <= mem_b[rd_ptr];
         alu_opcode <= mem_op[rd_ptr];
      end
   end

   // WAIT-cycle timer
   always_ff @(posedge clk) begin
      if (reset_a) begin
         tmr <= '0;
      end else if (pop) begin
         tmr <= '0;
      end else if (state == ST_WAIT) begin
         tmr <= tmr + 1'b1;
      end
   end

   // Result register; a set and a host read never coincide because an issue
   // is blocked while res_valid is high.
   always_ff @(posedge clk) begin
      if (reset_a) begin
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_carry   <= 1'b0;
         res_zero    <= 1'b0;
         res_timeout <= 1'b0;
      end else if (done_hit) begin
         res_valid   <= 1'b1;
         res_data    <= alu_out;
         res_carry   <= alu_carry;
         res_zero    <= alu_zero;
         res_timeout <= 1'b0;
      end else if (tmo_hit) begin
         res_valid   <= 1'b1;
         res_data    <= '0;
         res_carry   <= 1'b0;
         res_zero    <= 1'b0;
         res_timeout <= 1'b1;
      end else if (res_rd && res_valid) begin
         res_valid <= 1'b0;
      end
   end

   // busy lags the FSM/FIFO state by one cycle
   always_ff @(posedge clk) begin
      if (reset_a) begin
         busy <= 1'b0;
      end else begin
         busy <= (state != ST_IDLE) || !empty;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset_a;
   logic        cmd_wr;
   logic [15:0] cmd_dataa;
   logic [15:0] cmd_datab;
   logic [3:0]  cmd_opcode;
   logic        cmd_full;
   logic        cmd_overflow;
   logic [15:0] alu_dataa;
   logic [15:0] alu_datab;
   logic [3:0]  alu_opcode;
   logic        alu_start;
   logic [31:0] alu_out;
   logic        alu_carry;
   logic        alu_zero;
   logic        alu_done;
   logic        res_valid;
   logic [31:0] res_data;
   logic        res_carry;
   logic        res_zero;
   logic        res_timeout;
   logic        res_rd;
   logic        busy;

   logic model_done;
   logic force_done;
   logic alu_en;

   assign alu_done = model_done | force_done;

   always #5 clk = ~clk;

   alu_sequencer #(.DEPTH(4), .TIMEOUT(8)) dut (
      .clk(clk), .reset_a(reset_a),
      .cmd_wr(cmd_wr), .cmd_dataa(cmd_dataa), .cmd_datab(cmd_datab),
      .cmd_opcode(cmd_opcode), .cmd_full(cmd_full), .cmd_overflow(cmd_overflow),
      .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_opcode(alu_opcode),
      .alu_start(alu_start), .alu_out(alu_out), .alu_carry(alu_carry),
      .alu_zero(alu_zero), .alu_done(alu_done),
      .res_valid(res_valid), .res_data(res_data), .res_carry(res_carry),
      .res_zero(res_zero), .res_timeout(res_timeout), .res_rd(res_rd),
      .busy(busy)
   );

   typedef struct {
      logic [31:0] data;
      logic        carry;
      logic        zero;
      logic        tmo;
   } res_t;

   res_t        res_q[$];
   logic [15:0] iss_q[$];
   int n_checks = 0;
   int n_pass   = 0;
   int starts   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // ALU model: done arrives in the third cycle after the start pulse
   initial begin
      logic        st;
      int          pend;
      logic [15:0] la;
      logic [15:0] lb;
      logic [3:0]  lop;
      logic [16:0] s17;
      model_done = 1'b0; alu_out = '0; alu_carry = 1'b0; alu_zero = 1'b0;
      pend = 0; la = '0; lb = '0; lop = '0;
      forever begin
         @(posedge clk);
         st = alu_start;
         #1;
         model_done = 1'b0;
         if (st && alu_en) begin
            pend = 3; la = alu_dataa; lb = alu_datab; lop = alu_opcode;
         end else if (pend > 0) begin
            pend--;
            if (pend == 1) begin
               alu_carry = 1'b0;
               case (lop)
                  4'd0: begin
                     s17 = {1'b0, la} + {1'b0, lb};
                     alu_out = {15'b0, s17}; alu_carry = s17[16];
                  end
                  4'd1: begin
                     s17 = {1'b0, la} - {1'b0, lb};
                     alu_out = {16'b0, s17[15:0]}; alu_carry = s17[16];
                  end
                  4'd2:    alu_out = {16'b0, la & lb};
                  default: alu_out = {16'b0, la} * {16'b0, lb};
               endcase
               alu_zero = (alu_out == 32'd0);
               model_done = 1'b1;
            end
         end
      end
   end

   // Monitor: checks issue order on every start pulse and each new result
   initial begin
      logic prev_v;
      res_t e;
      prev_v = 1'b0;
      forever begin
         @(negedge clk);
         if (alu_start) begin
            starts++;
            if (iss_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_start: alu_dataa=0x%0h, no issue expected", alu_dataa);
            end else begin
               check("issue_order", {16'b0, alu_dataa}, {16'b0, iss_q.pop_front()});
            end
         end
         if (res_valid && !prev_v) begin
            if (res_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_result: res_data=0x%0h, no result expected", res_data);
            end else begin
               e = res_q.pop_front();
               check("res_data", res_data, e.data);
               check("res_flags", {29'b0, res_carry, res_zero, res_timeout},
                     {29'b0, e.carry, e.zero, e.tmo});
            end
         end
         prev_v = res_valid;
      end
   end

   task automatic write_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                            input bit q_iss, input bit q_res, input logic [31:0] ed,
                            input logic ec, input logic ez, input logic et);
      res_t r;
      cmd_wr = 1'b1; cmd_dataa = a; cmd_datab = b; cmd_opcode = op;
      if (q_iss) iss_q.push_back(a);
      if (q_res) begin
         r.data = ed; r.carry = ec; r.zero = ez; r.tmo = et;
         res_q.push_back(r);
      end
      @(negedge clk);
      cmd_wr = 1'b0;
   endtask

   task automatic wait_start(input int bound, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!alu_start && n < bound);
      if (!alu_start) begin
         n_checks++;
         $display("FAIL wait_start: no alu_start within %0d cycles", bound);
      end
   endtask

   task automatic wait_valid(input int bound, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (!res_valid && n < bound);
      if (!res_valid) begin
         n_checks++;
         $display("FAIL wait_valid: no res_valid within %0d cycles", bound);
      end
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((res_q.size() != 0 || iss_q.size() != 0) && n < bound) begin
         @(negedge clk); n++;
      end
      check(name, 32'(res_q.size() + iss_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      reset_a = 1'b1; cmd_wr = 1'b0; cmd_dataa = '0; cmd_datab = '0; cmd_opcode = '0;
      res_rd = 1'b0; alu_en = 1'b1; force_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_start",    {31'b0, alu_start},    32'd0);
      check("rst_valid",    {31'b0, res_valid},    32'd0);
      check("rst_full",     {31'b0, cmd_full},     32'd0);
      check("rst_overflow", {31'b0, cmd_overflow}, 32'd0);
      check("rst_busy",     {31'b0, busy},         32'd0);
      reset_a = 1'b0;
      @(negedge clk);

      // Single op plus backpressure: two commands, result held unread
      write_cmd(16'h0003, 16'h0004, 4'd0, 1, 1, 32'd7, 1'b0, 1'b0, 1'b0);
      write_cmd(16'hFFFF, 16'h0001, 4'd0, 1, 1, 32'h0001_0000, 1'b1, 1'b0, 1'b0);
      check("start_cycle1", {31'b0, alu_start}, 32'd1);
      n = 1;
      while (!res_valid && n < 40) begin @(negedge clk); n++; end
      check("done_latency", 32'(n), 32'd5);
      repeat (5) @(negedge clk);
      check("held_one_start", 32'(starts), 32'd1);
      check("held_valid", {31'b0, res_valid}, 32'd1);
      res_rd = 1'b1;
      @(negedge clk);
      res_rd = 1'b0;
      check("rd_clears_valid", {31'b0, res_valid}, 32'd0);
      check("no_issue_same_edge", {31'b0, alu_start}, 32'd0);
      @(negedge clk);
      check("issue_after_rd", {31'b0, alu_start}, 32'd1);
      wait_valid(40, n);
      check("two_starts", 32'(starts), 32'd2);

      // Overflow with the ALU stalled; result 2 still held so nothing pops
      alu_en = 1'b0;
      for (int i = 0; i < 4; i++)
         write_cmd(16'h0101 + 16'(i), 16'h0000, 4'd0, 1, 1, 32'd0, 1'b0, 1'b0, 1'b1);
      check("full_after_4", {31'b0, cmd_full}, 32'd1);
      check("no_ovf_after_4", {31'b0, cmd_overflow}, 32'd0);
      write_cmd(16'h0105, 16'h0000, 4'd0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
      check("ovf_after_5", {31'b0, cmd_overflow}, 32'd1);
      check("full_after_5", {31'b0, cmd_full}, 32'd1);
      res_rd = 1'b1;
      wait_start(40, n);
      check("issue_gap_after_rd", 32'(n), 32'd2);
      wait_valid(40, n);
      check("timeout_latency", 32'(n), 32'd9);
      check("timeout_flag", {31'b0, res_timeout}, 32'd1);
      wait_start(40, n);
      check("issue_after_timeout", 32'(n), 32'd2);
      wait_drain("overflow_drain", 200);
      repeat (3) @(negedge clk);

      // Back-to-back with res_rd tied high
      alu_en = 1'b1;
      write_cmd(16'h0005, 16'h0005, 4'd1, 1, 1, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
      write_cmd(16'h0FF0, 16'h00FF, 4'd2, 1, 1, 32'h0000_00F0, 1'b0, 1'b0, 1'b0);
      write_cmd(16'h1234, 16'h0010, 4'd3, 1, 1, 32'h0001_2340, 1'b0, 1'b0, 1'b0);
      write_cmd(16'h0002, 16'h0009, 4'd1, 1, 1, 32'h0000_FFF9, 1'b1, 1'b0, 1'b0);
      check("b2b_not_full", {31'b0, cmd_full}, 32'd0);
      wait_drain("b2b_drain", 200);
      repeat (3) @(negedge clk);
      check("b2b_starts", 32'(starts), 32'd10);

      // Reset in the middle of WAIT, then a stray done
      alu_en = 1'b0; res_rd = 1'b0;
      write_cmd(16'h0AAA, 16'h0001, 4'd0, 1, 0, 32'd0, 1'b0, 1'b0, 1'b0);
      write_cmd(16'h0BBB, 16'h0002, 4'd0, 0, 0, 32'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      reset_a = 1'b1;
      @(negedge clk);
      reset_a = 1'b0; force_done = 1'b1;
      check("mid_rst_outs", {alu_dataa, 11'b0, alu_start, cmd_full, cmd_overflow, busy, res_valid},
            32'd0);
      check("mid_rst_ops", {alu_datab, 12'b0, alu_opcode}, 32'd0);
      check("mid_rst_res", res_data | {29'b0, res_carry, res_zero, res_timeout}, 32'd0);
      @(negedge clk);
      force_done = 1'b0;
      check("late_done_ignored", {31'b0, res_valid}, 32'd0);
      repeat (20) @(negedge clk);
      check("fifo_flushed_starts", 32'(starts), 32'd11);
      check("idle_after_rst", {30'b0, busy, res_valid}, 32'd0);
      check("queues_empty", 32'(res_q.size() + iss_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-side initiator for the ALU subsystem: accepts operand/opcode commands from a host, buffers them in a small FIFO, and drives them one at a time into the ALU's start/done handshake. It captures each ALU result and its carry/zero flags into a one-entry result register that the host drains, and reports a timeout if the ALU fails to signal done. It sits between the host bus logic and the ALU top level, owning the ALU's dataa/datab/opcode/start inputs.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; must be a power of 2, at least 2.
- TIMEOUT, 255: maximum WAIT cycles before a result is forced with a timeout; at least 1.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_a  in  1  synchronous reset, active-high.
- cmd_wr  in  1  write strobe for one command.
- cmd_dataa  in  16  operand A.
- cmd_datab  in  16  operand B.
- cmd_opcode  in  4  ALU opcode.
- cmd_full  out  1  high when the FIFO holds DEPTH entries.
- cmd_overflow  out  1  sticky; set when a write is dropped.
- alu_dataa  out  16  to the ALU dataa input.
- alu_datab  out  16  to the ALU datab input.
- alu_opcode  out  4  to the ALU opcode input.
- alu_start  out  1  one-cycle start pulse to the ALU.
- alu_out  in  32  ALU result.
- alu_carry  in  1  ALU carry flag.
- alu_zero  in  1  ALU zero flag.
- alu_done  in  1  ALU done flag.
- res_valid  out  1  result register is full.
- res_data  out  32  captured result.
- res_carry  out  1  captured carry flag.
- res_zero  out  1  captured zero flag.
- res_timeout  out  1  result was forced by timeout.
- res_rd  in  1  host acknowledge; frees the result register.
- busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

## Operation
- The FIFO uses circular read/write pointers that wrap modulo DEPTH, plus an occupancy count from 0 to DEPTH.
  - A write with cmd_full=1 is dropped and sets cmd_overflow. This holds even if a pop occurs in the same cycle; cmd_full is evaluated on the pre-edge count.
  - A write and a pop in the same cycle on a non-full FIFO leave the count unchanged.
- The FSM has three states: IDLE, ISSUE and WAIT.
  - IDLE → ISSUE when the FIFO is non-empty and res_valid=0. On that edge it pops the head entry into the alu_dataa/alu_datab/alu_opcode registers and clears the timeout counter.
  - ISSUE: alu_start=1 for exactly this one cycle. → WAIT unconditionally. alu_done is ignored in ISSUE.
  - WAIT: the counter increments every cycle.
    - If alu_done=1: capture alu_out, alu_carry and alu_zero into res_*, set res_valid=1 and res_timeout=0, then → IDLE.
    - Else, if the counter reaches TIMEOUT: set res_data=0, res_carry=0, res_zero=0, res_valid=1 and res_timeout=1, then → IDLE.
    - alu_done takes priority over a timeout in the same cycle.
- alu_dataa/alu_datab/alu_opcode stay stable from ISSUE until the next ISSUE.
- res_rd with res_valid=1 clears res_valid at the next edge; res_rd with res_valid=0 is ignored. res_rd does not change res_data.
- Results are never overwritten: an issue is blocked while res_valid=1. A res_rd in IDLE allows an issue at the following edge, not the same one.
- Reset (any state, including mid-WAIT):
  - FSM returns to IDLE and the FIFO is emptied.
  - All outputs go to 0: alu_start, alu_dataa/datab/opcode, res_*, cmd_overflow, busy, and cmd_full.
  - An in-flight ALU operation is abandoned; its late alu_done is ignored because the FSM is in IDLE.

## Timing
- Edge numbering: cmd_wr is sampled at edge 0 (FIFO empty, IDLE, res_valid=0). At edge 1 the FSM is in ISSUE and alu_start is high during cycle 1. At edge 2 the FSM is in WAIT.
- Result capture: if alu_done is first high in WAIT cycle k, res_valid is high from edge k+1.
- Minimum issue-to-issue spacing is 4 cycles: ISSUE, WAIT (done in its first cycle), IDLE, then res_rd handling.
- Timeout: res_valid rises TIMEOUT+1 edges after the ISSUE edge.
- busy is registered and goes low the cycle after the FSM returns to IDLE with the FIFO empty.

## Test plan
- Single op: A=0x0003, B=0x0004, opcode=ADD; the ALU model returns done 3 cycles after start with out=7. Required: exactly one alu_start pulse, then res_valid with res_data=7, res_carry=0, res_zero=0, res_timeout=0.
- Back-to-back: write 4 commands in 4 consecutive cycles with res_rd tied high. Required: 4 ordered results, one alu_start per command, and cmd_full high after the 4th write if no pop has occurred yet.
- Overflow: with DEPTH=4, write 5 commands while the ALU is stalled (done never asserted). Required: the 5th write is dropped, cmd_overflow=1, and the first 4 commands execute in order.
- Timeout: TIMEOUT=8, alu_done held 0. Required: res_valid rises 9 edges after the ISSUE edge with res_timeout=1 and res_data=0; the next queued command then issues after res_rd.
- Backpressure: hold res_rd=0 with 2 commands queued. Required: only one alu_start; the second issues 1 cycle after res_rd is pulsed.
- Reset mid-WAIT: assert reset_a during WAIT, then pulse alu_done. Required: all outputs are 0, no res_valid, and the FIFO is empty.
